led_strip_driver: RTL and testbench

LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

---
 rtl/led_strip_driver.sv | 198 +++++++++++++++++++
 tb/tb_led_strip_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_driver.sv
// WS2812-style serial LED strip driver: streams NUM_LEDS pixels of BPP bits MSB first, then holds a latch gap.
// Latency: led_out rises on the edge that accepts the first pixel; bits are back to back, then TRESET_CYC low cycles and a frame_done pulse.
// Backpressure: pixel_ready/pixel_valid handshake with a one-entry prefetch; a missing pixel at a pixel boundary aborts the frame (underrun).
module led_strip_driver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int NUM_LEDS  = 8,
    parameter int BPP       = 24,
    parameter int T0H_NS    = 400,
    parameter int T1H_NS    = 800,
    parameter int TBIT_NS   = 1250,
    parameter int TRESET_NS = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [BPP-1:0] pixel_data,
    input  logic           pixel_valid,
    output logic           pixel_ready,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun,
    output logic           led_out
);

    // Nanoseconds to clock cycles, truncated, never below one cycle. 64-bit math avoids overflow of freq*ns.
    function automatic int ns2cyc(input longint freq, input longint ns);
        longint c;
        c = (freq * ns) / 64'sd1_000_000_000;
        if (c < 64'sd1) c = 64'sd1;
        return int'(c);
    endfunction

    localparam int T0H_CYC    = ns2cyc(longint'(CLK_FREQ), longint'(T0H_NS));
    localparam int T1H_CYC    = ns2cyc(longint'(CLK_FREQ), longint'(T1H_NS));
    localparam int TBIT_CYC   = ns2cyc(longint'(CLK_FREQ), longint'(TBIT_NS));
    localparam int TRESET_CYC = ns2cyc(longint'(CLK_FREQ), longint'(TRESET_NS));

    // Bit-cycle counter must also be able to hold the high times it is compared against.
    localparam int CMAX = (TBIT_CYC > T1H_CYC) ? TBIT_CYC : T1H_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LW   = $clog2(TRESET_CYC + 1);
    localparam int PW   = $clog2(NUM_LEDS + 1);
    localparam int BW   = (BPP > 1) ? $clog2(BPP) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYC);
    localparam logic [LW-1:0] LAT_END  = LW'(TRESET_CYC);
    localparam logic [PW-1:0] PX_LAST  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] ACC_MAX  = PW'(NUM_LEDS);
    localparam logic [BW-1:0] BIT_TOP  = BW'(BPP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_BIT   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [BPP-1:0] shift_q, shift_d;
    logic [BPP-1:0] hold_q, hold_d;
    logic           hold_vld_q, hold_vld_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic [PW-1:0]  acc_q, acc_d;     // pixels accepted this frame
    logic [PW-1:0]  px_q, px_d;       // index of the pixel in the shift register
    logic           underrun_q, underrun_d;
    logic           led_q, led_d;
    logic           hs, bit_end, pix_end;

    // Ready only while a pixel can actually be stored: FIRST, or BIT with an empty prefetch slot and quota left.
    always_comb begin
        pixel_ready = 1'b0;
        case (state_q)
            S_FIRST: pixel_ready = 1'b1;
            S_BIT:   pixel_ready = !hold_vld_q && (acc_q < ACC_MAX);
            default: pixel_ready = 1'b0;
        endcase
    end

    assign hs      = pixel_valid && pixel_ready;
    assign bit_end = (cyc_q == CYC_LAST);
    assign pix_end = bit_end && (bit_q == '0);

    // Frame sequencing, bit timing and prefetch bookkeeping.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_d      = bit_q;
        cyc_d      = cyc_q;
        lat_d      = lat_q;
        acc_d      = acc_q;
        px_d       = px_q;
        underrun_d = underrun_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FIRST;
                    underrun_d = 1'b0;
                    acc_d      = '0;
                    px_d       = '0;
                    hold_vld_d = 1'b0;
                end
            end
            S_FIRST: begin
                if (hs) begin
                    shift_d = pixel_data;
                    bit_d   = BIT_TOP;
                    cyc_d   = '0;
                    acc_d   = acc_q + PW'(1);
                    px_d    = '0;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                // Prefetch into the holding slot; a pixel arriving on the boundary cycle bypasses it below.
                if (hs && !pix_end) begin
                    hold_d     = pixel_data;
                    hold_vld_d = 1'b1;
                    acc_d      = acc_q + PW'(1);
                end
                if (!bit_end) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d = '0;
                    if (bit_q != '0) begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - BW'(1);
                    end else if (px_q == PX_LAST) begin
                        state_d = S_LATCH;
                        lat_d   = '0;
                    end else if (hold_vld_q) begin
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        bit_d      = BIT_TOP;
                        px_d       = px_q + PW'(1);
                    end else if (hs) begin
                        shift_d = pixel_data;
                        acc_d   = acc_q + PW'(1);
                        bit_d   = BIT_TOP;
                        px_d    = px_q + PW'(1);
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_LATCH;
                        lat_d      = '0;
                    end
                end
            end
            default: begin
                if (lat_q == LAT_END) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
        endcase
        // Registered line level derived from the next bit position, so led_out is glitch-free.
        led_d = (state_d == S_BIT) && (cyc_d < (shift_d[BPP-1] ? T1H_C : T0H_C));
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            bit_q      <= '0;
            cyc_q      <= '0;
            lat_q      <= '0;
            acc_q      <= '0;
            px_q       <= '0;
            underrun_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            bit_q      <= bit_d;
            cyc_q      <= cyc_d;
            lat_q      <= lat_d;
            acc_q      <= acc_d;
            px_q       <= px_d;
            underrun_q <= underrun_d;
            led_q      <= led_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_LATCH) && (lat_q == LAT_END);
    assign underrun   = underrun_q;
    assign led_out    = led_q;

endmodule

// File: tb/tb_led_strip_driver.sv
// Directed bench for led_strip_driver: 3-pixel frames, underrun, ignored starts, 32-bit pixels, async reset.
// Samples outputs on the falling edge; drives inputs 1 time unit after the rising edge.
// Pixel sources keep valid high whenever they have data, so data is offered as soon as ready rises.
module tb_led_strip_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 3-pixel strip at default timing (62-cycle bits, 2500-cycle latch)
    logic        start = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready, busy, frame_done, underrun, led_out;

    // 1-pixel GRBW strip at 100 MHz (125-cycle bits, 500-cycle latch)
    logic        start2 = 1'b0;
    logic [31:0] pixel_data2 = '0;
    logic        pixel_valid2 = 1'b0;
    logic        pixel_ready2, busy2, frame_done2, underrun2, led_out2;

    led_strip_driver #(.NUM_LEDS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .busy(busy), .frame_done(frame_done), .underrun(underrun), .led_out(led_out));

    led_strip_driver #(.CLK_FREQ(100_000_000), .NUM_LEDS(1), .BPP(32), .TRESET_NS(5000)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pixel_data(pixel_data2), .pixel_valid(pixel_valid2),
        .pixel_ready(pixel_ready2), .busy(busy2), .frame_done(frame_done2), .underrun(underrun2), .led_out(led_out2));

    int n_chk = 0;
    int n_fail = 0;

    // source state
    logic [23:0] src_dat[$];
    int src_idx = 0, src_lim = 0;
    logic src2_en = 1'b0, src2_done = 1'b0;
    logic start_until_fd = 1'b0;

    // line monitors
    int cyc_n = 0;
    int hi1[$], lo1[$], hi2[$], lo2[$];
    logic prev1, prev2;
    int run1, run2, first_rise1, first_rise2, last_fall1, last_fall2;
    int fd_cnt1, fd_cnt2, fd_time1, fd_time2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic mon_clear();
        hi1.delete(); lo1.delete(); hi2.delete(); lo2.delete();
        prev1 = led_out; prev2 = led_out2; run1 = 0; run2 = 0;
        first_rise1 = -1; first_rise2 = -1; last_fall1 = -1; last_fall2 = -1;
        fd_cnt1 = 0; fd_cnt2 = 0; fd_time1 = -1; fd_time2 = -1;
    endtask

    // One clock: sample at the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic hs1, hs2, fd_now;
        @(negedge clk);
        cyc_n++;
        hs1 = pixel_valid && pixel_ready;
        hs2 = pixel_valid2 && pixel_ready2;
        fd_now = frame_done;
        if (led_out !== prev1) begin
            if (led_out) begin
                if (first_rise1 < 0) first_rise1 = cyc_n; else lo1.push_back(run1);
            end else begin
                hi1.push_back(run1);
                last_fall1 = cyc_n;
            end
            run1 = 1;
        end else run1++;
        prev1 = led_out;
        if (led_out2 !== prev2) begin
            if (led_out2) begin
                if (first_rise2 < 0) first_rise2 = cyc_n; else lo2.push_back(run2);
            end else begin
                hi2.push_back(run2);
                last_fall2 = cyc_n;
            end
            run2 = 1;
        end else run2++;
        prev2 = led_out2;
        if (frame_done)  begin fd_cnt1++; fd_time1 = cyc_n; end
        if (frame_done2) begin fd_cnt2++; fd_time2 = cyc_n; end
        @(posedge clk);
        #1;
        if (hs1) src_idx++;
        pixel_valid = (src_idx < src_lim) && (src_idx < src_dat.size());
        pixel_data  = (src_idx < src_dat.size()) ? src_dat[src_idx] : 24'h0;
        if (hs2) src2_done = 1'b1;
        pixel_valid2 = src2_en && !src2_done;
        if (start_until_fd && fd_now) begin
            start = 1'b0;
            start_until_fd = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fd(input int budget);
        for (int i = 0; i < budget && fd_cnt1 == 0; i++) tick();
    endtask

    task automatic wait_fd2(input int budget);
        for (int i = 0; i < budget && fd_cnt2 == 0; i++) tick();
    endtask

    // Frame of FF00FF, 00FF00, 0000FF: '1' = 40 high / 22 low, '0' = 20 high / 42 low.
    task automatic check_frame_a(input string nm);
        logic [71:0] bits;
        int eh, ah, al;
        bits = {24'hFF00FF, 24'h00FF00, 24'h0000FF};
        chk($sformatf("%s high_count", nm), hi1.size(), 72);
        for (int i = 0; i < 72; i++) begin
            eh = bits[71-i] ? 40 : 20;
            ah = (i < hi1.size()) ? hi1[i] : -1;
            chk($sformatf("%s hi%0d", nm, i), ah, eh);
            if (i < 71) begin
                al = (i < lo1.size()) ? lo1[i] : -1;
                chk($sformatf("%s lo%0d", nm, i), al, 62 - eh);
            end
        end
        chk($sformatf("%s rise_to_done", nm), fd_time1 - first_rise1, 4464 + 2500);
        chk($sformatf("%s lastfall_to_done", nm), fd_time1 - last_fall1, 22 + 2500);
        chk($sformatf("%s done_pulses", nm), fd_cnt1, 1);
        chk($sformatf("%s underrun", nm), 32'(underrun), 0);
        chk($sformatf("%s accepted", nm), src_idx, 3);
    endtask

    initial begin
        src_dat = '{24'hFF00FF, 24'h00FF00, 24'h0000FF};
        src_lim = 3;
        mon_clear();

        // reset state
        ticks(3);
        chk("rst led_out", 32'(led_out), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pixel_ready", 32'(pixel_ready), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst underrun", 32'(underrun), 0);
        chk("rst ready2", 32'(pixel_ready2), 0);
        rst = 1'b0;
        ticks(5);
        chk("idle no consume", src_idx, 0);
        chk("idle busy", 32'(busy), 0);

        // frame A: plain 3-pixel frame
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("A busy after start", 32'(busy), 1);
        chk("A ready in FIRST", 32'(pixel_ready), 1);
        wait_fd(8000);
        tick();
        check_frame_a("A");
        chk("A busy after", 32'(busy), 0);

        // frame B: pixel 1 withheld until pixel 0 has finished
        src_idx = 0;
        src_lim = 1;
        pixel_valid = 1'b1;
        pixel_data = src_dat[0];
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(1500);
        src_lim = 2;
        wait_fd(4000);
        tick();
        chk("B high_count", hi1.size(), 24);
        chk("B underrun", 32'(underrun), 1);
        chk("B done_pulses", fd_cnt1, 1);
        chk("B lastfall_to_done", fd_time1 - last_fall1, 22 + 2500);
        chk("B late pixel", src_idx, 1);
        ticks(3);
        chk("B underrun sticky", 32'(underrun), 1);
        chk("B late pixel idle", src_idx, 1);

        // frame C: start held through the whole frame, dropped after frame_done
        src_idx = 0;
        src_lim = 3;
        pixel_data = src_dat[0];
        mon_clear();
        start = 1'b1;
        start_until_fd = 1'b1;
        tick();
        tick();
        chk("C underrun cleared", 32'(underrun), 0);
        wait_fd(8000);
        ticks(5);
        check_frame_a("C");
        chk("C no restart busy", 32'(busy), 0);
        chk("C no restart ready", 32'(pixel_ready), 0);

        // frame E: 32-bit pixel 80000001 at 100 MHz
        src2_en = 1'b1;
        src2_done = 1'b0;
        pixel_data2 = 32'h8000_0001;
        pixel_valid2 = 1'b1;
        mon_clear();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_fd2(12000);
        tick();
        chk("E high_count", hi2.size(), 32);
        for (int i = 0; i < 32; i++) begin
            int eh, ah, al;
            eh = (i == 0 || i == 31) ? 80 : 40;
            ah = (i < hi2.size()) ? hi2[i] : -1;
            chk($sformatf("E hi%0d", i), ah, eh);
            if (i < 31) begin
                al = (i < lo2.size()) ? lo2[i] : -1;
                chk($sformatf("E lo%0d", i), al, 125 - eh);
            end
        end
        chk("E done_pulses", fd_cnt2, 1);
        chk("E lastfall_to_done", fd_time2 - last_fall2, 45 + 500);
        chk("E underrun", 32'(underrun2), 0);
        chk("E accepted", 32'(src2_done), 1);
        src2_en = 1'b0;

        // frame D: asynchronous reset while the line is high
        src_idx = 0;
        pixel_data = src_dat[0];
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && led_out !== 1'b1; i++) tick();
        ticks(10);
        #1;
        chk("D led high before rst", 32'(led_out), 1);
        rst = 1'b1;
        #1;
        chk("D rst led_out", 32'(led_out), 0);
        chk("D rst busy", 32'(busy), 0);
        chk("D rst ready", 32'(pixel_ready), 0);
        chk("D rst frame_done", 32'(frame_done), 0);
        chk("D rst underrun", 32'(underrun), 0);
        ticks(3);
        rst = 1'b0;
        src_idx = 0;
        pixel_data = src_dat[0];
        mon_clear();
        ticks(3000);
        chk("D no frame_done", fd_cnt1, 0);
        chk("D idle busy", 32'(busy), 0);
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_fd(8000);
        tick();
        check_frame_a("D");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
